// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 matrix keypad scanner with shared per-key debounce and event FIFO
//
// Drives one keypad row at a time for TICK_DIV clocks, samples the columns at the
// end of each dwell, then walks the four keys of that row through a small
// debounce state machine (one column per clock). Debounced press/release events
// are queued in a 4-deep FIFO.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   col_in[3:0]  raw column inputs, active-high, asynchronous to clk
//   row_out[3:0] one-hot row drive, active-high
//   key_valid    FIFO head holds an event
//   key_code     head event key index {row, col}
//   key_press    head event type (1 = press, 0 = release)
//   key_ready    consumer accepts the head event
//   any_pressed  some key is debounced-down (Pressed or Released)
module keypad_scan_ctrl #(
  parameter int TICK_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_press,
  input  logic       key_ready,
  output logic       any_pressed
);

  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    K_IDLE     = 2'd0,
    K_GLITCH   = 2'd1,
    K_PRESSED  = 2'd2,
    K_RELEASED = 2'd3
  } key_state_t;

  logic [3:0]    col_m;
  logic [3:0]    col_s;
  logic [PW-1:0] pcnt;
  logic          step_end;
  logic [1:0]    r;
  logic [3:0]    samp;
  logic [1:0]    srow;
  logic          upd_active;
  logic [1:0]    upd_col;
  key_state_t    kst [16];
  logic [4:0]    fifo_mem [4];
  logic [1:0]    wr_ptr;
  logic [1:0]    rd_ptr;
  logic [2:0]    count;

  logic [3:0]    upd_key;
  logic          upd_bit;
  key_state_t    cur_state;
  key_state_t    nxt_state;
  logic          push_req;
  logic          push_press;
  logic          push_ok;
  logic          state_we;
  logic          pop;

  // Column synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_m <= 4'd0;
      col_s <= 4'd0;
    end else begin
      col_m <= col_in;
      col_s <= col_m;
    end
  end

  // Prescaler and row sequencing
  assign step_end = (pcnt == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt    <= '0;
      r       <= 2'd0;
      row_out <= 4'b0001;
    end else begin
      if (step_end) begin
        pcnt    <= '0;
        r       <= r + 2'd1;
        // row_out always equals one-hot(r), so advancing r is a rotate
        row_out <= {row_out[2:0], row_out[3]};
      end else begin
        pcnt <= pcnt + PW'(1);
      end
    end
  end

  // Sample capture and the 4-cycle update phase that follows it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp       <= 4'd0;
      srow       <= 2'd0;
      upd_active <= 1'b0;
      upd_col    <= 2'd0;
    end else begin
      if (upd_active) begin
        upd_col <= upd_col + 2'd1;
        if (upd_col == 2'd3) begin
          upd_active <= 1'b0;
        end
      end
      // TICK_DIV >= 8 guarantees the previous phase has finished here
      if (step_end) begin
        samp       <= col_s;
        srow       <= r;
        upd_active <= 1'b1;
        upd_col    <= 2'd0;
      end
    end
  end

  // Debounce next-state for the key currently being updated
  always_comb begin
    upd_key    = {srow, upd_col};
    upd_bit    = samp[upd_col];
    cur_state  = kst[upd_key];
    nxt_state  = cur_state;
    push_req   = 1'b0;
    push_press = 1'b0;
    case (cur_state)
      K_IDLE: begin
        if (upd_bit) nxt_state = K_GLITCH;
      end
      K_GLITCH: begin
        if (upd_bit) begin
          nxt_state  = K_PRESSED;
          push_req   = 1'b1;
          push_press = 1'b1;
        end else begin
          nxt_state = K_IDLE;
        end
      end
      K_PRESSED: begin
        if (!upd_bit) nxt_state = K_RELEASED;
      end
      K_RELEASED: begin
        if (upd_bit) begin
          nxt_state = K_PRESSED;
        end else begin
          nxt_state = K_IDLE;
          push_req  = 1'b1;
        end
      end
      default: nxt_state = K_IDLE;
    endcase
    // Full check uses the pre-pop count; a blocked transition leaves the key
    // untouched so the same event is retried on the row's next scan.
    push_ok  = upd_active && push_req && (count != 3'd4);
    state_we = upd_active && (!push_req || push_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        kst[i] <= K_IDLE;
      end
    end else if (state_we) begin
      kst[upd_key] <= nxt_state;
    end
  end

  always_comb begin
    any_pressed = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if ((kst[i] == K_PRESSED) || (kst[i] == K_RELEASED)) begin
        any_pressed = 1'b1;
      end
    end
  end

  // Event FIFO
  assign key_valid = (count != 3'd0);
  assign pop       = key_valid && key_ready;
  assign key_code  = fifo_mem[rd_ptr][3:0];
  assign key_press = fifo_mem[rd_ptr][4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        fifo_mem[i] <= 5'd0;
      end
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr] <= {push_press, upd_key};
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
